parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
- Serialising stage directly downstream of the 3-bit even-parity generator.
- Latches a data word together with the generator's parity bit and transmits it as an asynchronous-style serial frame: start bit, data LSB-first, parity, stop.
- Recomputes even parity on the latched word and flags a mismatch with the supplied parity bit.
- Output feeds a single-wire link or a UART-style receiver.

Parameters:
- DATA_W, 3: data word width in bits; must be ≥1.
- BIT_CYCLES, 4: clock cycles each serial bit is held; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  word to transmit.
- parity_in  input  1  even-parity bit from the upstream generator (XOR of data_in bits).
- load  input  1  request to start a frame; sampled only when busy=0.
- busy  output  1  high while a frame is in progress.
- tx  output  1  registered serial line; idles high.
- done  output  1  one-cycle pulse after the stop bit completes.
- perr  output  1  latched parity mismatch for the current or last frame.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, done=0, perr=0, state=IDLE, bit counter=0, cycle counter=0.
- rst overrides everything, including mid-frame. The next cycle shows idle line values and the frame is abandoned; no done pulse is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - On load=1, latch data_in and parity_in into shift/parity registers.
  - Set perr = (XOR of data_in) ^ parity_in.
  - Go to START.
- START: tx=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA:
  - tx = latched bit[index], LSB first.
  - Each bit is held BIT_CYCLES cycles.
  - After bit DATA_W-1, go to PARITY.
- PARITY: tx = latched parity_in for BIT_CYCLES cycles. The supplied bit is sent, not the recomputed one, even if perr=1.
- STOP: tx=1 for BIT_CYCLES cycles, then go to IDLE with done=1 for exactly that first IDLE cycle.
- Latency and timing:
  - The edge that samples load puts tx=0 and busy=1 in the following cycle.
  - Frame occupies (DATA_W+3)*BIT_CYCLES cycles of busy=1.
- Handshake:
  - load is ignored while busy=1; it does not queue and does not disturb latched data.
  - load=1 in the cycle done=1 (busy=0) is accepted, giving back-to-back frames with no idle gap beyond that one cycle.
- perr:
  - Updates only on an accepted load.
  - Holds through the frame and afterwards until the next accepted load or reset.
- data_in and parity_in changes after acceptance have no effect on the frame in flight.
- Cycle counter:
  - Counts 0..BIT_CYCLES-1 and wraps at each bit boundary.
  - With BIT_CYCLES=1 each bit lasts exactly one cycle.
  - Counter width is ceil(log2(BIT_CYCLES)) with a minimum of 1.

Test Plan:
- Reset, then load=1 with data_in=3'b101, parity_in=0:
  - busy=1 for 24 cycles.
  - tx sequence 0,1,0,1,0,1, each value held 4 cycles.
  - done pulses once at cycle 25.
  - perr=0.
- data_in=3'b111, parity_in=0 (wrong):
  - perr=1 from the cycle after load.
  - Parity slot transmits 0.
  - A following frame with 3'b011/parity 0 clears perr to 0.
- Frame 3'b110/0 in progress; pulse load with data_in=3'b001 at cycle 10:
  - Ignored; tx sequence stays 0,0,1,1,0,1.
  - Exactly one done pulse.
- Hold load=1 continuously with data alternating 3'b100/1 and 3'b010/1:
  - Frames repeat every 25 cycles.
  - done is coincident with acceptance of the next frame.
  - No dropped or merged frames.
- Assert rst during the DATA state of a frame:
  - Next cycle tx=1, busy=0, perr=0, done=0.
  - A new load afterwards produces a complete correct frame.
- Rebuild with BIT_CYCLES=1, DATA_W=8, data_in=8'hA5, parity_in=0:
  - 11-cycle frame with tx 0,1,0,1,0,0,1,0,1,0,1.
  - perr=0.

Source files
------------

// File: rtl/parity_frame_tx.sv
// Serial framer for a data word plus its upstream even-parity bit.
// Frame: start(0), data LSB-first, supplied parity, stop(1); each bit held BIT_CYCLES clocks.
module parity_frame_tx #(
  parameter int DATA_W     = 3,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              load,
  output logic              busy,
  output logic              tx,
  output logic              done,
  output logic              perr
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cyc_reg, cyc_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [DATA_W-1:0] word_reg;
  logic              par_reg;
  logic              tx_reg, tx_next;
  logic              done_reg, done_next;
  logic              perr_reg;
  logic              accept;
  logic              bit_end;

  assign accept  = (state_reg == IDLE) && load;
  assign bit_end = (cyc_reg == CYC_LAST);

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      idx_reg   <= '0;
      word_reg  <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
      if (accept) begin
        word_reg <= data_in;
        par_reg  <= parity_in;
        perr_reg <= (^data_in) ^ parity_in;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    idx_next   = idx_reg;
    if (state_reg != IDLE) begin
      cyc_next = bit_end ? '0 : cyc_reg + 1'b1;
    end
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = START;
          cyc_next   = '0;
          idx_next   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_reg == IDX_LAST) begin
            state_next = PARITY;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is decoded from the upcoming state so the line itself is a flop.
  always_comb begin
    tx_next   = 1'b1;
    done_next = (state_reg == STOP) && bit_end;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = word_reg[idx_next];
      PARITY:  tx_next = par_reg;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign tx   = tx_reg;
  assign done = done_reg;
  assign perr = perr_reg;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: default 3-bit/4-cycle instance and an 8-bit/1-cycle instance.
module tb_parity_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] a_data;
  logic       a_par, a_load;
  logic       a_busy, a_tx, a_done, a_perr;
  logic [7:0] b_data;
  logic       b_par, b_load;
  logic       b_busy, b_tx, b_done, b_perr;

  int checks   = 0;
  int failures = 0;

  logic rec_tx   [0:31];
  logic rec_busy [0:31];
  logic rec_done [0:31];

  parity_frame_tx u_a (
    .clk(clk), .rst(rst), .data_in(a_data), .parity_in(a_par), .load(a_load),
    .busy(a_busy), .tx(a_tx), .done(a_done), .perr(a_perr)
  );

  parity_frame_tx #(.DATA_W(8), .BIT_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .data_in(b_data), .parity_in(b_par), .load(b_load),
    .busy(b_busy), .tx(b_tx), .done(b_done), .perr(b_perr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles of the default instance; optionally pulse a load at cycle index inj.
  task automatic capture(input int n, input int inj, input logic [2:0] inj_data);
    for (int i = 0; i < n; i++) begin
      rec_tx[i]   = a_tx;
      rec_busy[i] = a_busy;
      rec_done[i] = a_done;
      if (inj >= 0 && i == inj) begin
        a_load = 1'b1;
        a_data = inj_data;
        a_par  = 1'b0;
      end else if (inj >= 0 && i == inj + 1) begin
        a_load = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_load = 1'b0; a_data = '0; a_par = 1'b0;
    b_load = 1'b0; b_data = '0; b_par = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 || a_perr !== 1'b0) begin
      failures++;
      $display("FAIL reset_a tx=%b busy=%b done=%b perr=%b expected 1 0 0 0", a_tx, a_busy, a_done, a_perr);
    end
    checks++;
    if (b_tx !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_perr !== 1'b0) begin
      failures++;
      $display("FAIL reset_b tx=%b busy=%b done=%b perr=%b expected 1 0 0 0", b_tx, b_busy, b_done, b_perr);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    logic [5:0] seq = 6'b010101;
    step();
    a_load = 1'b1; a_data = 3'b101; a_par = 1'b0;
    step();
    a_load = 1'b0;
    capture(24, -1, 3'b000);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (rec_tx[i] !== seq[5 - i/4] || rec_busy[i] !== 1'b1 || rec_done[i] !== 1'b0) begin
        failures++;
        $display("FAIL basic_frame cycle=%0d tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                 i + 1, rec_tx[i], rec_busy[i], rec_done[i], seq[5 - i/4]);
      end
    end
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_tx !== 1'b1 || a_perr !== 1'b0) begin
      failures++;
      $display("FAIL basic_done done=%b busy=%b tx=%b perr=%b expected 1 0 1 0", a_done, a_busy, a_tx, a_perr);
    end
    step();
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width done=%b expected 0", a_done);
    end
    $display("frame data=101 par=0 perr=%b", a_perr);
  endtask

  task automatic test_parity_error();
    logic [5:0] seq1 = 6'b011101;
    logic [5:0] seq2 = 6'b011001;
    a_load = 1'b1; a_data = 3'b111; a_par = 1'b0;
    step();
    a_load = 1'b0;
    checks++;
    if (a_perr !== 1'b1) begin
      failures++;
      $display("FAIL perr_set perr=%b expected 1", a_perr);
    end
    capture(24, -1, 3'b000);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (rec_tx[i] !== seq1[5 - i/4] || rec_busy[i] !== 1'b1) begin
        failures++;
        $display("FAIL perr_frame cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                 i + 1, rec_tx[i], rec_busy[i], seq1[5 - i/4]);
      end
    end
    checks++;
    if (a_done !== 1'b1 || a_perr !== 1'b1) begin
      failures++;
      $display("FAIL perr_hold done=%b perr=%b expected 1 1", a_done, a_perr);
    end
    $display("frame data=111 par=0 perr=%b", a_perr);
    step();
    a_load = 1'b1; a_data = 3'b011; a_par = 1'b0;
    step();
    a_load = 1'b0;
    checks++;
    if (a_perr !== 1'b0) begin
      failures++;
      $display("FAIL perr_clear perr=%b expected 0", a_perr);
    end
    capture(24, -1, 3'b000);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (rec_tx[i] !== seq2[5 - i/4]) begin
        failures++;
        $display("FAIL clear_frame cycle=%0d tx=%b expected %b", i + 1, rec_tx[i], seq2[5 - i/4]);
      end
    end
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL clear_done done=%b expected 1", a_done);
    end
    $display("frame data=011 par=0 perr=%b", a_perr);
    step();
  endtask

  task automatic test_ignore_load();
    logic [5:0] seq = 6'b001101;
    int pulses = 0;
    a_load = 1'b1; a_data = 3'b110; a_par = 1'b0;
    step();
    a_load = 1'b0;
    capture(24, 9, 3'b001);
    for (int i = 0; i < 24; i++) begin
      if (rec_done[i] === 1'b1) pulses++;
      checks++;
      if (rec_tx[i] !== seq[5 - i/4] || rec_busy[i] !== 1'b1) begin
        failures++;
        $display("FAIL ignore_frame cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                 i + 1, rec_tx[i], rec_busy[i], seq[5 - i/4]);
      end
    end
    if (a_done === 1'b1) pulses++;
    checks++;
    if (pulses != 1 || a_perr !== 1'b0) begin
      failures++;
      $display("FAIL ignore_done pulses=%0d perr=%b expected 1 0", pulses, a_perr);
    end
    step();
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_no_queue busy=%b done=%b expected 0 0", a_busy, a_done);
    end
    $display("frame data=110 par=0 with ignored load, done pulses=%0d", pulses);
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq_100 = 6'b000111;
    logic [5:0] seq_010 = 6'b001011;
    logic [5:0] seq;
    a_load = 1'b1; a_data = 3'b100; a_par = 1'b1;
    step();
    for (int f = 0; f < 3; f++) begin
      seq = (f % 2 == 0) ? seq_100 : seq_010;
      a_data = (f % 2 == 0) ? 3'b010 : 3'b100;
      if (f == 2) a_load = 1'b0;
      capture(24, -1, 3'b000);
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (rec_tx[i] !== seq[5 - i/4] || rec_busy[i] !== 1'b1 || rec_done[i] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_frame%0d cycle=%0d tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                   f, i + 1, rec_tx[i], rec_busy[i], rec_done[i], seq[5 - i/4]);
        end
      end
      checks++;
      if (a_done !== 1'b1 || a_busy !== 1'b0 || a_perr !== 1'b0) begin
        failures++;
        $display("FAIL b2b_done%0d done=%b busy=%b perr=%b expected 1 0 0", f, a_done, a_busy, a_perr);
      end
      step();
      checks++;
      if (f < 2) begin
        if (a_busy !== 1'b1 || a_tx !== 1'b0 || a_done !== 1'b0) begin
          failures++;
          $display("FAIL b2b_restart%0d busy=%b tx=%b done=%b expected 1 0 0", f, a_busy, a_tx, a_done);
        end
      end else begin
        if (a_busy !== 1'b0 || a_tx !== 1'b1) begin
          failures++;
          $display("FAIL b2b_end busy=%b tx=%b expected 0 1", a_busy, a_tx);
        end
      end
      $display("back-to-back frame %0d sent", f);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] seq = 6'b010101;
    int pulses = 0;
    a_load = 1'b1; a_data = 3'b111; a_par = 1'b0;
    step();
    a_load = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_perr !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset tx=%b busy=%b perr=%b done=%b expected 1 0 0 0", a_tx, a_busy, a_perr, a_done);
    end
    for (int i = 0; i < 30; i++) begin
      if (a_done === 1'b1 || a_busy === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL mid_reset_abandon activity_cycles=%0d expected 0", pulses);
    end
    a_load = 1'b1; a_data = 3'b101; a_par = 1'b0;
    step();
    a_load = 1'b0;
    capture(24, -1, 3'b000);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (rec_tx[i] !== seq[5 - i/4] || rec_busy[i] !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_frame cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                 i + 1, rec_tx[i], rec_busy[i], seq[5 - i/4]);
      end
    end
    checks++;
    if (a_done !== 1'b1 || a_perr !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_done done=%b perr=%b expected 1 0", a_done, a_perr);
    end
    $display("frame after mid-frame reset sent, perr=%b", a_perr);
    step();
  endtask

  task automatic test_wide_fast();
    logic [10:0] seq = 11'b01010010101;
    b_load = 1'b1; b_data = 8'hA5; b_par = 1'b0;
    step();
    b_load = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (b_tx !== seq[10 - i] || b_busy !== 1'b1 || b_done !== 1'b0) begin
        failures++;
        $display("FAIL wide_frame cycle=%0d tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                 i + 1, b_tx, b_busy, b_done, seq[10 - i]);
      end
      step();
    end
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_tx !== 1'b1 || b_perr !== 1'b0) begin
      failures++;
      $display("FAIL wide_done done=%b busy=%b tx=%b perr=%b expected 1 0 1 0", b_done, b_busy, b_tx, b_perr);
    end
    $display("wide frame data=A5 par=0 perr=%b", b_perr);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_ignore_load();
    test_back_to_back();
    test_reset_mid_frame();
    test_wide_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
